mem_arbiter: RTL and testbench

- Downstream neighbour of the core top level. Merges the instruction-fetch memory port and the load/store memory port onto one shared memory bus.
- Masters and memory all use valid/ready request channels and a valid-only response channel.
- Exactly one transaction is outstanding at a time. Each response is routed back to the master that issued the request.
- Lets the core move from private instruction/data memories to a single unified memory slave.

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Memory-style request/response channel shared by the fetch port, the
// load/store port and the unified memory bus. The request channel uses a
// valid/ready handshake. The response channel is valid-only.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  wen;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rdata;

    // Requester side: issues requests and consumes responses.
    modport master (
        output req_valid, wen, addr, wdata, wstrb,
        input  req_ready, rsp_valid, rdata
    );

    // Responder side: accepts requests and returns responses.
    modport slave (
        input  req_valid, wen, addr, wdata, wstrb,
        output req_ready, rsp_valid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-into-one memory arbiter. It merges the instruction-fetch port and the
// load/store port onto a single memory bus, with one transaction in flight
// at a time. Each response is returned to the master that issued the request.
// Optional feature: define ARB_RR_EN for round-robin arbitration on
// contention. Without it, arbitration is fixed priority and LS wins.
// The fetch port is read-only. Its wen/wdata/wstrb inputs are not used.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  if_port,
    mem_arbiter_if.slave  ls_port,
    mem_arbiter_if.master mem_port
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
    typedef enum logic       {OWN_IF, OWN_LS} owner_e;

`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_e                state, state_next;
    owner_e                owner, last_owner;
    logic                  req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;

    logic                  grant_ls;
    logic                  accept;
    logic                  rsp_hit;

    // Grant decision. LS wins contention unless round-robin picks the non-last owner.
    always_comb begin
        grant_ls = ls_port.req_valid;
        if (if_port.req_valid && ls_port.req_valid) begin
            grant_ls = RR_EN ? (last_owner == OWN_IF) : 1'b1;
        end
    end

    assign accept  = (state == IDLE) &&
                     (grant_ls ? ls_port.req_valid : if_port.req_valid);
    assign rsp_hit = (state == RSP) && mem_port.rsp_valid;

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its inputs from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first. This prevents
    // latch inference on paths that do not assign it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)                state_next = REQ;
            REQ:     if (mem_port.req_ready)    state_next = RSP;
            RSP:     if (mem_port.rsp_valid)    state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Request registers, owner and last_owner bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_IF;
            last_owner <= OWN_LS;
            req_wen    <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wstrb  <= '0;
        end else begin
            if (accept) begin
                if (grant_ls) begin
                    owner     <= OWN_LS;
                    req_wen   <= ls_port.wen;
                    req_addr  <= ls_port.addr;
                    req_wdata <= ls_port.wdata;
                    req_wstrb <= ls_port.wstrb;
                end else begin
                    owner     <= OWN_IF;
                    req_wen   <= 1'b0;
                    req_addr  <= if_port.addr;
                    req_wdata <= '0;
                    req_wstrb <= '0;
                end
            end
            if (rsp_hit) begin
                last_owner <= owner;
            end
        end
    end

    // Output decode: readies in IDLE, memory request in REQ, response routing in RSP.
    always_comb begin
        // NOTE: the readies are combinational from IDLE. They are gated with
        // rst_n so they read 0 while reset is held, even though the state is IDLE.
        if_port.req_ready  = rst_n && (state == IDLE) && !grant_ls;
        ls_port.req_ready  = rst_n && (state == IDLE) &&  grant_ls;

        mem_port.req_valid = (state == REQ);
        mem_port.wen       = req_wen;
        mem_port.addr      = req_addr;
        mem_port.wdata     = req_wdata;
        mem_port.wstrb     = req_wstrb;

        if_port.rsp_valid  = 1'b0;
        if_port.rdata      = '0;
        ls_port.rsp_valid  = 1'b0;
        ls_port.rdata      = '0;
        if (rsp_hit) begin
            if (owner == OWN_LS) begin
                ls_port.rsp_valid = 1'b1;
                ls_port.rdata     = mem_port.rdata;
            end else begin
                if_port.rsp_valid = 1'b1;
                if_port.rdata     = mem_port.rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A table of transaction vectors is
// driven in lockstep. Expected memory requests and responses go into a
// queue at accept time and are popped when the memory request appears.
// Hand-written sequences cover reset, contention, mid-RSP reset and stray
// responses in IDLE. Expectations follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) fetch_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_port  (fetch_bus),
        .ls_port  (lsu_bus),
        .mem_port (mem_bus)
    );

    typedef struct {
        bit          if_v;
        bit          ls_v;
        bit          wen;
        logic [31:0] if_addr;
        logic [31:0] ls_addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          stall;
        int          rsp_wait;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        bit          to_ls;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t scoreboard[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   model_last_ls = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit exp_grant_ls(input bit ifv, input bit lsv);
`ifdef ARB_RR_EN
        if (ifv && lsv) return !model_last_ls;
`endif
        return lsv;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_bus.req_valid = 1'b0;
        fetch_bus.wen       = 1'b0;
        fetch_bus.addr      = '0;
        fetch_bus.wdata     = '0;
        fetch_bus.wstrb     = '0;
        lsu_bus.req_valid   = 1'b0;
        lsu_bus.wen         = 1'b0;
        lsu_bus.addr        = '0;
        lsu_bus.wdata       = '0;
        lsu_bus.wstrb       = '0;
        mem_bus.req_ready   = 1'b0;
        mem_bus.rsp_valid   = 1'b0;
        mem_bus.rdata       = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".if_ready"},  fetch_bus.req_ready, 0);
        check({tag, ".ls_ready"},  lsu_bus.req_ready,   0);
        check({tag, ".mem_valid"}, mem_bus.req_valid,   0);
        check({tag, ".mem_addr"},  mem_bus.addr,        0);
        check({tag, ".mem_wen"},   mem_bus.wen,         0);
        check({tag, ".mem_wdata"}, mem_bus.wdata,       0);
        check({tag, ".mem_wstrb"}, mem_bus.wstrb,       0);
        check({tag, ".if_rsp"},    fetch_bus.rsp_valid, 0);
        check({tag, ".ls_rsp"},    lsu_bus.rsp_valid,   0);
        check({tag, ".if_rdata"},  fetch_bus.rdata,     0);
        check({tag, ".ls_rdata"},  lsu_bus.rdata,       0);
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_last_ls = 1'b1;
    endtask

    // Run one full transaction from IDLE back to IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        bit    g;
        exp_t  e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        fetch_bus.req_valid = v.if_v;
        fetch_bus.addr      = v.if_addr;
        lsu_bus.req_valid   = v.ls_v;
        lsu_bus.wen         = v.wen;
        lsu_bus.addr        = v.ls_addr;
        lsu_bus.wdata       = v.wdata;
        lsu_bus.wstrb       = v.wstrb;
        #1;
        g = exp_grant_ls(v.if_v, v.ls_v);
        check({tag, ".if_ready"}, fetch_bus.req_ready, !g);
        check({tag, ".ls_ready"}, lsu_bus.req_ready,   g);
        e.to_ls = g;
        e.wen   = g ? v.wen   : 1'b0;
        e.addr  = g ? v.ls_addr : v.if_addr;
        e.wdata = g ? v.wdata : 32'h0;
        e.wstrb = g ? v.wstrb : 4'h0;
        e.rdata = v.rdata;
        scoreboard.push_back(e);

        step();
        fetch_bus.req_valid = 1'b0;
        lsu_bus.req_valid   = 1'b0;
        #1;
        check({tag, ".mem_valid"}, mem_bus.req_valid, 1);
        check({tag, ".rdy_req"}, {fetch_bus.req_ready, lsu_bus.req_ready}, 0);
        check({tag, ".sb_size"}, scoreboard.size(), 1);
        if (scoreboard.size() == 0) return;
        e = scoreboard.pop_front();
        check({tag, ".mem_addr"},  mem_bus.addr,  e.addr);
        check({tag, ".mem_wen"},   mem_bus.wen,   e.wen);
        check({tag, ".mem_wdata"}, mem_bus.wdata, e.wdata);
        check({tag, ".mem_wstrb"}, mem_bus.wstrb, e.wstrb);
        for (int k = 0; k < v.stall; k++) begin
            step();
            check({tag, ".stall_valid"}, mem_bus.req_valid, 1);
            check({tag, ".stall_addr"},  mem_bus.addr, e.addr);
            check({tag, ".stall_rdy"},   {fetch_bus.req_ready, lsu_bus.req_ready}, 0);
        end
        mem_bus.req_ready = 1'b1;
        step();
        mem_bus.req_ready = 1'b0;
        #1;
        check({tag, ".rsp_state_valid"}, mem_bus.req_valid, 0);
        for (int k = 0; k < v.rsp_wait; k++) begin
            check({tag, ".early_rsp"}, {fetch_bus.rsp_valid, lsu_bus.rsp_valid}, 0);
            check({tag, ".rsp_rdy"},   {fetch_bus.req_ready, lsu_bus.req_ready}, 0);
            step();
        end
        mem_bus.rsp_valid = 1'b1;
        mem_bus.rdata     = e.rdata;
        #1;
        check({tag, ".if_rsp"},   fetch_bus.rsp_valid, !e.to_ls);
        check({tag, ".ls_rsp"},   lsu_bus.rsp_valid,   e.to_ls);
        check({tag, ".if_rdata"}, fetch_bus.rdata, e.to_ls ? 32'h0 : e.rdata);
        check({tag, ".ls_rdata"}, lsu_bus.rdata,   e.to_ls ? e.rdata : 32'h0);
        step();
        mem_bus.rsp_valid = 1'b0;
        mem_bus.rdata     = '0;
        #1;
        check({tag, ".rsp_pulse_end"}, {fetch_bus.rsp_valid, lsu_bus.rsp_valid}, 0);
        check({tag, ".back_idle"}, fetch_bus.req_ready | lsu_bus.req_ready, 1);
        model_last_ls = g;
    endtask

    // Watchdog. The bench is lockstep, but it must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   g;
        bit   exp_g;
        vecs[0] = '{1, 0, 0, 32'h8000_0000, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0000_0413};
        vecs[1] = '{0, 1, 1, 32'h0,         32'h8000_1000, 32'hDEAD_BEEF, 4'h3, 0, 1, 32'h0};
        vecs[2] = '{1, 0, 0, 32'h8000_0004, 32'h0,         32'h0,         4'h0, 3, 0, 32'h00A0_0093};
        vecs[3] = '{0, 1, 0, 32'h0,         32'h8000_2000, 32'h5555_AAAA, 4'hF, 1, 2, 32'h1234_5678};
        vecs[4] = '{1, 1, 1, 32'h8000_0008, 32'h8000_3000, 32'hCAFE_F00D, 4'hC, 0, 0, 32'h0BAD_CAFE};
        vecs[5] = '{1, 1, 0, 32'h8000_000C, 32'h8000_3004, 32'h0,         4'h0, 1, 1, 32'h7777_0001};

        // Reset state, with requests and a stray response pending.
        idle_inputs();
        fetch_bus.req_valid = 1'b1;
        lsu_bus.req_valid   = 1'b1;
        mem_bus.rsp_valid   = 1'b1;
        mem_bus.rdata       = 32'hFFFF_FFFF;
        #2;
        check_all_zero("reset");
        apply_reset();

        // mem_rsp_valid in IDLE with no request.
        mem_bus.rsp_valid = 1'b1;
        mem_bus.rdata     = 32'hFFFF_FFFF;
        #1;
        check("idle_rsp.valid", {fetch_bus.rsp_valid, lsu_bus.rsp_valid}, 0);
        check("idle_rsp.rdata", {fetch_bus.rdata, lsu_bus.rdata}, 0);
        step();
        mem_bus.rsp_valid = 1'b0;
        mem_bus.rdata     = '0;
        #1;
        check("idle_rsp.still_idle", fetch_bus.req_ready, 1);
        check("idle_rsp.no_mem_req", mem_bus.req_valid, 0);

        // Table-driven transactions.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Continuous contention from reset, with the memory always ready and responding.
        apply_reset();
        fetch_bus.req_valid = 1'b1;
        fetch_bus.addr      = 32'h8000_0100;
        lsu_bus.req_valid   = 1'b1;
        lsu_bus.addr        = 32'h8000_4000;
        mem_bus.req_ready   = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            exp_g = exp_grant_ls(1'b1, 1'b1);
            g = lsu_bus.req_ready;
            check($sformatf("contend%0d.grant_ls", n), g, exp_g);
            check($sformatf("contend%0d.one_hot", n), fetch_bus.req_ready ^ lsu_bus.req_ready, 1);
            step();
            check($sformatf("contend%0d.addr", n), mem_bus.addr,
                  exp_g ? 32'h8000_4000 : 32'h8000_0100);
            step();
            mem_bus.rsp_valid = 1'b1;
            mem_bus.rdata     = 32'h100 + n;
            #1;
            check($sformatf("contend%0d.rsp", n), {fetch_bus.rsp_valid, lsu_bus.rsp_valid},
                  exp_g ? 2'b01 : 2'b10);
            step();
            mem_bus.rsp_valid = 1'b0;
            model_last_ls = exp_g;
        end
        idle_inputs();
        step();

        // Reset while in RSP: the transaction is dropped.
        fetch_bus.req_valid = 1'b1;
        fetch_bus.addr      = 32'h8000_0200;
        step();
        fetch_bus.req_valid = 1'b0;
        mem_bus.req_ready   = 1'b1;
        step();
        mem_bus.req_ready   = 1'b0;
        #1;
        check("midrst.in_rsp", {mem_bus.req_valid, fetch_bus.req_ready, lsu_bus.req_ready}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        rst_n = 1'b1;
        model_last_ls = 1'b1;
        mem_bus.rsp_valid = 1'b1;
        mem_bus.rdata     = 32'h0000_BEEF;
        #1;
        check("midrst.late_rsp", {fetch_bus.rsp_valid, lsu_bus.rsp_valid}, 0);
        step();
        mem_bus.rsp_valid = 1'b0;
        mem_bus.rdata     = '0;
        run_vec(vecs[0], 6);

        check("scoreboard_empty", scoreboard.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
